bnn_seq_hs: RTL and testbench

//  Two-layer sequential binary neural network classifier with start/valid handshake.

---
 rtl/bnn_seq_hs.sv | 243 ++++++++++++++++++++++++
 tb/tb_bnn_seq_hs.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_seq_hs.sv
// ---------------------------------------------------------------------------
// bnn_seq_hs
//   Two-layer sequential binary neural network classifier with a start/valid
//   handshake.
//     Layer 1: signed add/sub accumulation of B-bit unsigned features,
//              P features per cycle, into M hidden accumulators.
//     Layer 2: XNOR-popcount of the M hidden bits against each class,
//              P2 hidden bits per cycle.
//     Argmax:  one class per cycle; ties resolve to the lowest class index.
//   A new frame may be started from IDLE or DONE without a reset.
//
// Ports
//   clk    in   1            clock, rising edge
//   rst    in   1            asynchronous, active-high reset
//   start  in   1            request, accepted only while ready is high
//   data   in   N*B          feature n at data[n*B +: B], sampled on accept
//   ready  out  1            high in IDLE and DONE
//   valid  out  1            high in DONE; klass/score stable while high
//   klass  out  clog2(C)     winning class index
//   score  out  clog2(M+1)   popcount of the winning class
//   sums   out  C*clog2(M+1) per-class popcounts, class c at [c*SumL +: SumL]
//
// Build option
//   BNN_SUMS_EN  when defined, the sums port exists and exposes the class
//                popcount registers. They update during layer 2 and hold after
//                DONE. Without it the port is removed; the registers stay
//                because the argmax reads them.
// ---------------------------------------------------------------------------
module bnn_seq_hs #(
  parameter int N  = 128,
  parameter int B  = 4,
  parameter int M  = 40,
  parameter int C  = 6,
  parameter int P  = 1,
  parameter int P2 = 1,
  parameter logic [M*N-1:0] Weights0 = '0,
  parameter logic [C*M-1:0] Weights1 = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N*B-1:0]               data,
  output logic                         ready,
  output logic                         valid,
  output logic [$clog2(C)-1:0]         klass,
  output logic [$clog2(M+1)-1:0]       score
`ifdef BNN_SUMS_EN
  ,
  output logic [C*$clog2(M+1)-1:0]     sums
`endif
);

  localparam int SumL   = $clog2(M+1);
  localparam int AccW   = B + $clog2(N) + 1;
  localparam int KW     = $clog2(C);
  localparam int L1_CYC = N / P;
  localparam int L2_CYC = M / P2;
  localparam int MAXC   = (L1_CYC > L2_CYC) ? ((L1_CYC > C) ? L1_CYC : C)
                                            : ((L2_CYC > C) ? L2_CYC : C);
  localparam int CW     = $clog2(MAXC);
  localparam int PM     = P * M;

  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_ARG, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic                  accept;
  logic                  phase_last;

  logic [CW-1:0]         cnt_reg;
  logic [N*B-1:0]        frame_reg;
  logic [M*AccW-1:0]     acc_reg;
  logic [M-1:0]          hidden_reg;
  logic [C*SumL-1:0]     sum_reg;
  logic [SumL-1:0]       best_reg;
  logic [KW-1:0]         idx_reg;
  logic [KW-1:0]         klass_reg;
  logic [SumL-1:0]       score_reg;

  logic [M*AccW-1:0]     acc_sum;
  logic [M-1:0]          hidden_next;
  logic [C*SumL-1:0]     sum_step;
  logic [PM-1:0]         w0_slice;
  logic [P2-1:0]         hid_win;
  logic [SumL-1:0]       cur_sum;
  logic                  take;
  logic [SumL-1:0]       best_step;
  logic [KW-1:0]         idx_step;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    phase_last = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_L1;
        end
      end
      S_L1: begin
        phase_last = (cnt_reg == CW'(L1_CYC - 1));
        if (phase_last) state_next = S_L2;
      end
      S_L2: begin
        phase_last = (cnt_reg == CW'(L2_CYC - 1));
        if (phase_last) state_next = S_ARG;
      end
      S_ARG: begin
        phase_last = (cnt_reg == CW'(C - 1));
        if (phase_last) state_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_L1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign valid = (state_reg == S_DONE);
  assign klass = klass_reg;
  assign score = score_reg;

`ifdef BNN_SUMS_EN
  assign sums = sum_reg;
`endif

  // -------------------------------------------------------------------------
  // Layer 1: the frame register shifts right by P features each cycle, so the
  // current features always sit at the bottom. The matching weight columns
  // (features cnt*P .. cnt*P+P-1, all neurons) are selected once here.
  // -------------------------------------------------------------------------
  assign w0_slice = PM'(Weights0 >> (int'(cnt_reg) * PM));

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_neuron
      logic signed [AccW-1:0] acc_tmp;
      always_comb begin
        acc_tmp = $signed(acc_reg[gi*AccW +: AccW]);
        for (int p = 0; p < P; p++) begin
          if (w0_slice[p*M + gi])
            acc_tmp = acc_tmp + $signed(AccW'(frame_reg[p*B +: B]));
          else
            acc_tmp = acc_tmp - $signed(AccW'(frame_reg[p*B +: B]));
        end
      end
      assign acc_sum[gi*AccW +: AccW] = acc_tmp;
      // Non-negative (including zero) maps to 1.
      assign hidden_next[gi] = ~acc_tmp[AccW-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Layer 2: XNOR-popcount of the current P2 hidden bits against each class.
  // -------------------------------------------------------------------------
  assign hid_win = P2'(hidden_reg >> (int'(cnt_reg) * P2));

  generate
    for (gi = 0; gi < C; gi++) begin : g_class
      localparam logic [M-1:0] W1C = Weights1[gi*M +: M];
      logic [P2-1:0]   w1_win;
      logic [SumL-1:0] inc;
      always_comb begin
        w1_win = P2'(W1C >> (int'(cnt_reg) * P2));
        inc    = '0;
        for (int q = 0; q < P2; q++) begin
          inc = inc + SumL'(hid_win[q] == w1_win[q]);
        end
      end
      assign sum_step[gi*SumL +: SumL] = sum_reg[gi*SumL +: SumL] + inc;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Argmax: class cnt is examined in ARG cycle cnt. Strict greater-than keeps
  // the earliest class on a tie.
  // -------------------------------------------------------------------------
  assign cur_sum   = SumL'(sum_reg >> (int'(cnt_reg) * SumL));
  assign take      = (cnt_reg == '0) || (cur_sum > best_reg);
  assign best_step = take ? cur_sum : best_reg;
  assign idx_step  = take ? KW'(cnt_reg) : idx_reg;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg  <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      hidden_reg <= '0;
      sum_reg    <= '0;
      best_reg   <= '0;
      idx_reg    <= '0;
      klass_reg  <= '0;
      score_reg  <= '0;
    end else if (accept) begin
      // klass/score deliberately keep the previous result until the new DONE.
      frame_reg <= data;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      best_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        S_L1: begin
          acc_reg   <= acc_sum;
          frame_reg <= frame_reg >> (P * B);
          cnt_reg   <= phase_last ? '0 : cnt_reg + CW'(1);
          if (phase_last) hidden_reg <= hidden_next;
        end
        S_L2: begin
          sum_reg <= sum_step;
          cnt_reg <= phase_last ? '0 : cnt_reg + CW'(1);
        end
        S_ARG: begin
          best_reg <= best_step;
          idx_reg  <= idx_step;
          cnt_reg  <= phase_last ? '0 : cnt_reg + CW'(1);
          if (phase_last) begin
            klass_reg <= idx_step;
            score_reg <= best_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_hs.sv
// ---------------------------------------------------------------------------
// tb_bnn_seq_hs
//   Directed bench for bnn_seq_hs. Three tiny instances (N=4, M=4, C=2) cover
//   the hand-computed vectors, handshake, restart and mid-run reset. Two
//   default-size instances (P=4/P2=2 and P=1/P2=1) run 200 random frames,
//   checked against a behavioural model and the expected latencies.
// ---------------------------------------------------------------------------
module tb_bnn_seq_hs;

  localparam logic [5119:0] W0_BIG = {160{32'hA5C3_96E1}};
  localparam logic [239:0]  W1_BIG = {15{16'hC6A9}};

  logic clk;
  logic rst;

  // small instances share start/data
  logic        start_s;
  logic [15:0] data_s;
  logic        ready_a, valid_a, klass_a;
  logic        ready_b, valid_b, klass_b;
  logic        ready_c, valid_c, klass_c;
  logic [2:0]  score_a, score_b, score_c;
`ifdef BNN_SUMS_EN
  logic [5:0]  sums_a, sums_b, sums_c;
  logic [35:0] sums_p4, sums_p1;
`endif

  // default-size instances share start/data
  logic         start_b;
  logic [511:0] data_b;
  logic         ready_p4, valid_p4, ready_p1, valid_p1;
  logic [2:0]   klass_p4, klass_p1;
  logic [5:0]   score_p4, score_p1;

  int n_checks;
  int n_fail;

  bnn_seq_hs #(.N(4), .B(4), .M(4), .C(2), .P(1), .P2(1),
               .Weights0(16'hFFFF), .Weights1(8'hFF)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_s), .data(data_s),
    .ready(ready_a), .valid(valid_a), .klass(klass_a), .score(score_a)
`ifdef BNN_SUMS_EN
    , .sums(sums_a)
`endif
  );

  bnn_seq_hs #(.N(4), .B(4), .M(4), .C(2), .P(1), .P2(1),
               .Weights0(16'hFFFF), .Weights1(8'hF0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_s), .data(data_s),
    .ready(ready_b), .valid(valid_b), .klass(klass_b), .score(score_b)
`ifdef BNN_SUMS_EN
    , .sums(sums_b)
`endif
  );

  bnn_seq_hs #(.N(4), .B(4), .M(4), .C(2), .P(1), .P2(1),
               .Weights0(16'h0000), .Weights1(8'hF3)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_s), .data(data_s),
    .ready(ready_c), .valid(valid_c), .klass(klass_c), .score(score_c)
`ifdef BNN_SUMS_EN
    , .sums(sums_c)
`endif
  );

  bnn_seq_hs #(.N(128), .B(4), .M(40), .C(6), .P(4), .P2(2),
               .Weights0(W0_BIG), .Weights1(W1_BIG)) u_dut_p4 (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b),
    .ready(ready_p4), .valid(valid_p4), .klass(klass_p4), .score(score_p4)
`ifdef BNN_SUMS_EN
    , .sums(sums_p4)
`endif
  );

  bnn_seq_hs #(.N(128), .B(4), .M(40), .C(6), .P(1), .P2(1),
               .Weights0(W0_BIG), .Weights1(W1_BIG)) u_dut_p1 (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b),
    .ready(ready_p1), .valid(valid_p1), .klass(klass_p1), .score(score_p1)
`ifdef BNN_SUMS_EN
    , .sums(sums_p1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural reference for the default-size configuration.
  function automatic void model(input logic [511:0] d, output int k, output int s);
    logic [5119:0] w0;
    logic [239:0]  w1;
    logic [39:0]   hid;
    int            acc;
    int            sc;
    w0 = W0_BIG;
    w1 = W1_BIG;
    for (int m = 0; m < 40; m++) begin
      acc = 0;
      for (int n = 0; n < 128; n++) begin
        if (w0[n*40 + m]) acc += int'(d[n*4 +: 4]);
        else              acc -= int'(d[n*4 +: 4]);
      end
      hid[m] = (acc >= 0);
    end
    k = 0;
    s = -1;
    for (int c = 0; c < 6; c++) begin
      sc = 0;
      for (int m = 0; m < 40; m++) if (hid[m] == w1[c*40 + m]) sc++;
      if (c == 0 || sc > s) begin
        s = sc;
        k = c;
      end
    end
  endfunction

  // One transaction on the small instances. hk_c/hs_c are the klass/score
  // dut_c must still show right after the accepting edge (previous result).
  task automatic run_small(input string name, input logic [15:0] d, input bit busy_start,
                           input int ek_a, input int es_a, input int ek_b, input int es_b,
                           input int ek_c, input int es_c, input int hk_c, input int hs_c);
    int lat;
    @(negedge clk);
    data_s  = d;
    start_s = 1'b1;
    @(negedge clk);
    start_s = busy_start;
    data_s  = ~d;
    check({name, "_ready_busy"}, 32'(ready_a), 32'd0);
    check({name, "_valid_busy"}, 32'(valid_c), 32'd0);
    check({name, "_klass_held"}, 32'(klass_c), 32'(hk_c));
    check({name, "_score_held"}, 32'(score_c), 32'(hs_c));
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (valid_a) break;
      start_s = busy_start;
    end
    start_s = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'd10);
    check({name, "_a_klass"}, 32'(klass_a), 32'(ek_a));
    check({name, "_a_score"}, 32'(score_a), 32'(es_a));
    check({name, "_b_klass"}, 32'(klass_b), 32'(ek_b));
    check({name, "_b_score"}, 32'(score_b), 32'(es_b));
    check({name, "_c_klass"}, 32'(klass_c), 32'(ek_c));
    check({name, "_c_score"}, 32'(score_c), 32'(es_c));
`ifdef BNN_SUMS_EN
    check({name, "_b_sums"}, 32'(sums_b), 32'd32);
`endif
    repeat (3) @(negedge clk);
    check({name, "_valid_hold"}, 32'(valid_a), 32'd1);
    check({name, "_ready_hold"}, 32'(ready_b), 32'd1);
    check({name, "_c_klass_hold"}, 32'(klass_c), 32'(ek_c));
    $display("%s: data=%h lat=%0d a=%0d/%0d b=%0d/%0d c=%0d/%0d",
             name, d, lat, klass_a, score_a, klass_b, score_b, klass_c, score_c);
  endtask

  initial begin
    int mk, ms, lat4, lat1, cyc;
    logic [511:0] d;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start_s  = 1'b0;
    data_s   = '0;
    start_b  = 1'b0;
    data_b   = '0;

    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(ready_a), 32'd1);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_klass_a", 32'(klass_a), 32'd0);
    check("rst_score_a", 32'(score_a), 32'd0);
    check("rst_ready_p4", 32'(ready_p4), 32'd1);
    check("rst_valid_p1", 32'(valid_p1), 32'd0);
    check("rst_score_p4", 32'(score_p4), 32'd0);
`ifdef BNN_SUMS_EN
    check("rst_sums_b", 32'(sums_b), 32'd0);
`endif
    $display("reset: ready=%0d valid=%0d klass=%0d score=%0d", ready_a, valid_a, klass_a, score_a);
    rst = 1'b0;

    // data all 15, start held through the busy phases
    run_small("busy_f", 16'hFFFF, 1'b1, 0, 4, 1, 4, 0, 2, 0, 0);
    // restart from DONE, data all 0
    run_small("restart_0", 16'h0000, 1'b0, 0, 4, 1, 4, 1, 4, 0, 2);

    // reset asserted in the middle of layer 2
    @(negedge clk);
    data_s  = 16'hFFFF;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(valid_c), 32'd0);
    check("midrst_ready", 32'(ready_c), 32'd1);
    check("midrst_klass", 32'(klass_c), 32'd0);
    check("midrst_score", 32'(score_c), 32'd0);
    $display("midrst: valid=%0d ready=%0d klass=%0d score=%0d", valid_c, ready_c, klass_c, score_c);
    @(negedge clk);
    rst = 1'b0;
    run_small("after_rst", 16'hFFFF, 1'b0, 0, 4, 1, 4, 0, 2, 0, 0);

    // default-size random frames: P=4/P2=2 and P=1/P2=1 versus the model
    for (int f = 0; f < 200; f++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
      model(d, mk, ms);
      @(negedge clk);
      data_b  = d;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      data_b  = '0;
      lat4 = 0;
      lat1 = 0;
      cyc  = 0;
      while ((lat4 == 0 || lat1 == 0) && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (valid_p4 && lat4 == 0) lat4 = cyc;
        if (valid_p1 && lat1 == 0) lat1 = cyc;
      end
      check("big_lat_p4", 32'(lat4), 32'd58);
      check("big_lat_p1", 32'(lat1), 32'd174);
      check("big_klass_p4", 32'(klass_p4), 32'(mk));
      check("big_score_p4", 32'(score_p4), 32'(ms));
      check("big_klass_p1", 32'(klass_p1), 32'(mk));
      check("big_score_p1", 32'(score_p1), 32'(ms));
      $display("frame %0d: model=%0d/%0d p4=%0d/%0d lat=%0d p1=%0d/%0d lat=%0d",
               f, mk, ms, klass_p4, score_p4, lat4, klass_p1, score_p1, lat1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
